// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - RV32I decode stage with forwarding, load-use bubbles and a registered ID/EX output
//
// Purpose: decodes the instruction held in IF/ID, selects operands (regfile or
// forwarded), and registers the decoded op into ID/EX behind a valid/ready handshake.
// Optional feature macro: ID_STALL_CNT_EN (adds stall_cnt_o).
//
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   if_valid_i / if_ready_o        instruction handshake from IF/ID
//   pc_i, inst_i                   instruction pc and word
//   reg{1,2}_read_o/_addr_o        combinational regfile read request
//   reg{1,2}_data_i                regfile read data
//   fwd_wreg_i/fwd_wd_i/fwd_wdata_i later-stage write ports, index 0 youngest
//   fwd0_load_i                    source 0 is a load whose data is not ready
//   flush_i                        kill input and ID/EX contents
//   ex_ready_i / ex_valid_o        ID/EX handshake toward EX
//   ex_*_o                         registered decoded op
//   stall_cnt_o                    (ID_STALL_CNT_EN) stalled-input cycle count

`ifndef ID_STAGE_PIPE_DEFS
`define ID_STAGE_PIPE_DEFS
`define AluOpBus      7:0
`define AluSelBus     2:0
`define EXE_NOP_OP    8'h00
`define EXE_ADD_OP    8'h01
`define EXE_SUB_OP    8'h02
`define EXE_SLL_OP    8'h03
`define EXE_SLT_OP    8'h04
`define EXE_SLTU_OP   8'h05
`define EXE_XOR_OP    8'h06
`define EXE_SRL_OP    8'h07
`define EXE_SRA_OP    8'h08
`define EXE_OR_OP     8'h09
`define EXE_AND_OP    8'h0A
`define EXE_LUI_OP    8'h0B
`define EXE_AUIPC_OP  8'h0C
`define EXE_JAL_OP    8'h40
`define EXE_JALR_OP   8'h41
`define EXE_RES_NOP    3'd0
`define EXE_RES_LOGIC  3'd1
`define EXE_RES_SHIFT  3'd2
`define EXE_RES_ARITH  3'd3
`define EXE_RES_MEM    3'd4
`define EXE_RES_BRANCH 3'd5
`define EXE_RES_JUMP   3'd6
`endif

module id_stage_pipe #(
  parameter int XLEN      = 32,
  parameter int REGADDR_W = 5,
  parameter int NUM_FWD   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         if_valid_i,
  output logic                         if_ready_o,
  input  logic [XLEN-1:0]              pc_i,
  input  logic [31:0]                  inst_i,
  output logic                         reg1_read_o,
  output logic                         reg2_read_o,
  output logic [REGADDR_W-1:0]         reg1_addr_o,
  output logic [REGADDR_W-1:0]         reg2_addr_o,
  input  logic [XLEN-1:0]              reg1_data_i,
  input  logic [XLEN-1:0]              reg2_data_i,
  input  logic [NUM_FWD-1:0]           fwd_wreg_i,
  input  logic [NUM_FWD*REGADDR_W-1:0] fwd_wd_i,
  input  logic [NUM_FWD*XLEN-1:0]      fwd_wdata_i,
  input  logic                         fwd0_load_i,
  input  logic                         flush_i,
  input  logic                         ex_ready_i,
  output logic                         ex_valid_o,
  output logic [`AluOpBus]             ex_aluop_o,
  output logic [`AluSelBus]            ex_alusel_o,
  output logic [XLEN-1:0]              ex_reg1_o,
  output logic [XLEN-1:0]              ex_reg2_o,
  output logic [XLEN-1:0]              ex_imm_o,
  output logic [XLEN-1:0]              ex_pc_o,
  output logic [REGADDR_W-1:0]         ex_wd_o,
  output logic                         ex_wreg_o,
  output logic                         ex_illegal_o
`ifdef ID_STALL_CNT_EN
  ,
  output logic [31:0]                  stall_cnt_o
`endif
);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [REGADDR_W-1:0] rs1, rs2, rd;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];
  assign rd     = REGADDR_W'(inst_i[11:7]);
  assign rs1    = REGADDR_W'(inst_i[19:15]);
  assign rs2    = REGADDR_W'(inst_i[24:20]);

  // Signed fragments; size casts below sign-extend them to XLEN.
  logic signed [11:0] imm_i12, imm_s12;
  logic signed [12:0] imm_b13;
  logic signed [20:0] imm_j21;
  logic signed [31:0] imm_u32;
  assign imm_i12 = inst_i[31:20];
  assign imm_s12 = {inst_i[31:25], inst_i[11:7]};
  assign imm_b13 = {inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_j21 = {inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign imm_u32 = {inst_i[31:12], 12'b0};

  logic [`AluOpBus]  d_aluop;
  logic [`AluSelBus] d_alusel;
  logic [XLEN-1:0]   d_imm, op1_alt, op2_alt, op1, op2;
  logic              d_rd1, d_rd2, d_wreg, d_illegal;

  always_comb begin
    d_aluop   = `EXE_NOP_OP;
    d_alusel  = `EXE_RES_ARITH;
    d_imm     = '0;
    op1_alt   = '0;
    op2_alt   = '0;
    d_rd1     = 1'b0;
    d_rd2     = 1'b0;
    d_wreg    = (rd != '0);
    d_illegal = 1'b0;
    unique case (opcode)
      OPC_OP_IMM: begin
        d_rd1   = 1'b1;
        d_imm   = XLEN'(imm_i12);
        op2_alt = XLEN'(imm_i12);
        case (funct3)
          3'b000: d_aluop = `EXE_ADD_OP;
          3'b010: d_aluop = `EXE_SLT_OP;
          3'b011: d_aluop = `EXE_SLTU_OP;
          3'b100: begin d_aluop = `EXE_XOR_OP; d_alusel = `EXE_RES_LOGIC; end
          3'b110: begin d_aluop = `EXE_OR_OP;  d_alusel = `EXE_RES_LOGIC; end
          3'b111: begin d_aluop = `EXE_AND_OP; d_alusel = `EXE_RES_LOGIC; end
          default: begin
            // funct3 001/101: shifts; only inst[30] may be set, and only for SRAI.
            d_alusel = `EXE_RES_SHIFT;
            op2_alt  = XLEN'(inst_i[24:20]);
            if (funct3 == 3'b001)
              d_aluop = `EXE_SLL_OP;
            else
              d_aluop = inst_i[30] ? `EXE_SRA_OP : `EXE_SRL_OP;
            if (funct7 != {1'b0, inst_i[30] & funct3[2], 5'b0}) d_illegal = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        d_rd1 = 1'b1;
        d_rd2 = 1'b1;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000: d_aluop = `EXE_ADD_OP;
            3'b001: begin d_aluop = `EXE_SLL_OP; d_alusel = `EXE_RES_SHIFT; end
            3'b010: d_aluop = `EXE_SLT_OP;
            3'b011: d_aluop = `EXE_SLTU_OP;
            3'b100: begin d_aluop = `EXE_XOR_OP; d_alusel = `EXE_RES_LOGIC; end
            3'b101: begin d_aluop = `EXE_SRL_OP; d_alusel = `EXE_RES_SHIFT; end
            3'b110: begin d_aluop = `EXE_OR_OP;  d_alusel = `EXE_RES_LOGIC; end
            default: begin d_aluop = `EXE_AND_OP; d_alusel = `EXE_RES_LOGIC; end
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          d_aluop = `EXE_SUB_OP;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          d_aluop  = `EXE_SRA_OP;
          d_alusel = `EXE_RES_SHIFT;
        end else begin
          d_illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        d_aluop = `EXE_LUI_OP;
        d_imm   = XLEN'(imm_u32);
        op2_alt = XLEN'(imm_u32);
      end
      OPC_AUIPC: begin
        d_aluop = `EXE_AUIPC_OP;
        d_imm   = XLEN'(imm_u32);
        op1_alt = pc_i;
        op2_alt = XLEN'(imm_u32);
      end
      OPC_LOAD: begin
        d_rd1     = 1'b1;
        d_alusel  = `EXE_RES_MEM;
        d_imm     = XLEN'(imm_i12);
        d_aluop   = {5'b00100, funct3};
        d_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        d_rd1     = 1'b1;
        d_rd2     = 1'b1;
        d_wreg    = 1'b0;
        d_alusel  = `EXE_RES_MEM;
        d_imm     = XLEN'(imm_s12);
        d_aluop   = {5'b00101, funct3};
        d_illegal = funct3[2] || (funct3 == 3'b011);
      end
      OPC_BRANCH: begin
        d_rd1     = 1'b1;
        d_rd2     = 1'b1;
        d_wreg    = 1'b0;
        d_alusel  = `EXE_RES_BRANCH;
        d_imm     = XLEN'(imm_b13);
        d_aluop   = {5'b00110, funct3};
        d_illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_JAL, OPC_JALR: begin
        // Link value pc+4 is formed in EX from reg1/reg2; imm is the target offset.
        d_alusel  = `EXE_RES_JUMP;
        op1_alt   = pc_i;
        op2_alt   = XLEN'(4);
        d_aluop   = (opcode == OPC_JAL) ? `EXE_JAL_OP : `EXE_JALR_OP;
        d_imm     = (opcode == OPC_JAL) ? XLEN'(imm_j21) : XLEN'(imm_i12);
        d_illegal = (opcode == OPC_JALR) && (funct3 != 3'b000);
      end
      default: d_illegal = 1'b1;
    endcase
    if (d_illegal) begin
      // Illegal ops travel as harmless NOPs that read nothing, so they never stall.
      d_aluop  = `EXE_NOP_OP;
      d_alusel = `EXE_RES_NOP;
      d_wreg   = 1'b0;
      d_rd1    = 1'b0;
      d_rd2    = 1'b0;
      d_imm    = '0;
      op1_alt  = '0;
      op2_alt  = '0;
    end
  end

  assign reg1_read_o = d_rd1;
  assign reg2_read_o = d_rd2;
  assign reg1_addr_o = rs1;
  assign reg2_addr_o = rs2;

  // Descending scan so the lowest-index (youngest) match is the one that sticks.
  always_comb begin
    op1 = op1_alt;
    op2 = op2_alt;
    if (d_rd1) begin
      op1 = reg1_data_i;
      for (int k = NUM_FWD - 1; k >= 0; k--)
        if (fwd_wreg_i[k] && fwd_wd_i[k*REGADDR_W +: REGADDR_W] == rs1)
          op1 = fwd_wdata_i[k*XLEN +: XLEN];
      if (rs1 == '0) op1 = '0;
    end
    if (d_rd2) begin
      op2 = reg2_data_i;
      for (int k = NUM_FWD - 1; k >= 0; k--)
        if (fwd_wreg_i[k] && fwd_wd_i[k*REGADDR_W +: REGADDR_W] == rs2)
          op2 = fwd_wdata_i[k*XLEN +: XLEN];
      if (rs2 == '0) op2 = '0;
    end
  end

  logic [REGADDR_W-1:0] wd0;
  logic hazard, ld;
  assign wd0    = fwd_wd_i[REGADDR_W-1:0];
  assign hazard = fwd0_load_i && fwd_wreg_i[0] && (wd0 != '0) &&
                  ((d_rd1 && rs1 == wd0) || (d_rd2 && rs2 == wd0));
  assign ld         = !ex_valid_o || ex_ready_i;
  assign if_ready_o = flush_i || (ld && !hazard);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_o   <= 1'b0;
      ex_aluop_o   <= `EXE_NOP_OP;
      ex_alusel_o  <= `EXE_RES_NOP;
      ex_reg1_o    <= '0;
      ex_reg2_o    <= '0;
      ex_imm_o     <= '0;
      ex_pc_o      <= '0;
      ex_wd_o      <= '0;
      ex_wreg_o    <= 1'b0;
      ex_illegal_o <= 1'b0;
    end else if (flush_i) begin
      ex_valid_o <= 1'b0;
    end else if (ld && hazard) begin
      ex_valid_o <= 1'b0;
      ex_wreg_o  <= 1'b0;
    end else if (ld) begin
      ex_valid_o   <= if_valid_i;
      ex_aluop_o   <= d_aluop;
      ex_alusel_o  <= d_alusel;
      ex_reg1_o    <= op1;
      ex_reg2_o    <= op2;
      ex_imm_o     <= d_imm;
      ex_pc_o      <= pc_i;
      ex_wd_o      <= rd;
      ex_wreg_o    <= d_wreg && if_valid_i;
      ex_illegal_o <= d_illegal;
    end
  end

`ifdef ID_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt_o <= '0;
    else if (if_valid_i && !if_ready_o && stall_cnt_o != 32'hFFFF_FFFF)
      stall_cnt_o <= stall_cnt_o + 32'd1;
  end
`endif

endmodule
